// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, the load/store port and the single-port memory
//   side of mem_port_arbiter.
//   master : requester/memory side (drives requests and mem_rdata)
//   slave  : arbiter side (drives grants, responses and memory strobes)
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_gnt;
   logic                  if_rvalid;
   logic [DATA_WIDTH-1:0] if_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_WIDTH-1:0] d_rdata;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between an instruction-fetch port and a
//   load/store port. One access is in flight at a time; each access takes
//   MEM_LATENCY+1 cycles (grant cycle, then BUSY until the response).
//   Data has priority over fetch, except that after STARVE_LIMIT data grants
//   issued while fetch was waiting, fetch is forced through.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; also forces every output to 0
//   bus   : mem_port_arbiter_if.slave (fetch port, data port, memory side)
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LAT_C    = 4'(MEM_LATENCY);
   localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);

   typedef enum logic {IDLE, BUSY} state_e;
   typedef enum logic {OWN_IF, OWN_D} owner_e;

   state_e     state_q,      state_d;
   logic [3:0] lat_cnt_q,    lat_cnt_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   owner_e     owner_q,      owner_d;
   logic       store_q,      store_d;

   logic                  fetch_wins;
   logic                  if_gnt_c, d_gnt_c, mem_en_c, mem_we_c;
   logic                  if_rvalid_c, d_rvalid_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c, if_rdata_c, d_rdata_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lat_cnt_q    <= 4'd0;
         starve_cnt_q <= 4'd0;
         owner_q      <= OWN_IF;
         store_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         store_q      <= store_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      owner_d      = owner_q;
      store_d      = store_q;
      fetch_wins   = 1'b0;
      if_gnt_c     = 1'b0;
      d_gnt_c      = 1'b0;
      mem_en_c     = 1'b0;
      mem_we_c     = 1'b0;
      mem_addr_c   = '0;
      mem_wdata_c  = '0;
      if_rvalid_c  = 1'b0;
      d_rvalid_c   = 1'b0;
      if_rdata_c   = '0;
      d_rdata_c    = '0;

      case (state_q)
         IDLE: begin
            // Fetch only wins when data is absent or fetch has been starved.
            fetch_wins = bus.if_req && (!bus.d_req || starve_cnt_q == STARVE_C);
            if (bus.if_req || bus.d_req) begin
               mem_en_c  = 1'b1;
               state_d   = BUSY;
               lat_cnt_d = 4'd1;
               if (fetch_wins) begin
                  if_gnt_c     = 1'b1;
                  mem_addr_c   = bus.if_addr;
                  owner_d      = OWN_IF;
                  store_d      = 1'b0;
                  starve_cnt_d = 4'd0;
               end else begin
                  d_gnt_c     = 1'b1;
                  mem_we_c    = bus.d_we;
                  mem_addr_c  = bus.d_addr;
                  mem_wdata_c = bus.d_wdata;
                  owner_d     = OWN_D;
                  store_d     = bus.d_we;
                  // Only data grants that overtake a waiting fetch count.
                  if (bus.if_req && starve_cnt_q != STARVE_C)
                     starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         BUSY: begin
            lat_cnt_d = lat_cnt_q + 4'd1;
            if (lat_cnt_q == LAT_C) begin
               state_d = IDLE;
               if (owner_q == OWN_IF) begin
                  if_rvalid_c = 1'b1;
                  if_rdata_c  = bus.mem_rdata;
               end else begin
                  d_rvalid_c = 1'b1;
                  d_rdata_c  = store_q ? '0 : bus.mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are combinational from state and requests, so they must be
      // squashed directly while reset is held, not just via the flops.
      if (!rst_n) begin
         if_gnt_c    = 1'b0;
         d_gnt_c     = 1'b0;
         mem_en_c    = 1'b0;
         mem_we_c    = 1'b0;
         mem_addr_c  = '0;
         mem_wdata_c = '0;
         if_rvalid_c = 1'b0;
         d_rvalid_c  = 1'b0;
         if_rdata_c  = '0;
         d_rdata_c   = '0;
      end
   end

   assign bus.if_gnt    = if_gnt_c;
   assign bus.if_rvalid = if_rvalid_c;
   assign bus.if_rdata  = if_rdata_c;
   assign bus.d_gnt     = d_gnt_c;
   assign bus.d_rvalid  = d_rvalid_c;
   assign bus.d_rdata   = d_rdata_c;
   assign bus.mem_en    = mem_en_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int SLIM = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      bit            is_d;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   // reference model state: when the memory is next free, starvation count
   int   free_at = 0;
   int   starve  = 0;

   // requester state
   bit            if_pend, d_pend, if_got, d_got;
   logic [AW-1:0] if_a, d_a;
   logic          d_we_v;
   logic [DW-1:0] d_wd;

   // memory contents seen by the bench
   logic [DW-1:0] mem [logic [AW-1:0]];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctl"}, {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                          bus.if_rvalid, bus.d_rvalid}, 64'd0);
      chk({name, "_addr"}, {bus.mem_addr, bus.mem_wdata}, 64'd0);
      chk({name, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 64'd0);
   endtask

   task automatic drive();
      bus.if_req  = if_pend;
      bus.if_addr = if_a;
      bus.d_req   = d_pend;
      bus.d_we    = d_we_v;
      bus.d_addr  = d_a;
      bus.d_wdata = d_wd;
   endtask

   // One clock cycle: new requests after the edge, optional reset actions,
   // then the model's expectation checked at the falling edge.
   task automatic step(input int p_if, input int p_d, input bit rel, input bit pulse, input bit st);
      bit e_f, e_d, idle;
      logic [DW-1:0] rd;
      @(posedge clk);
      #1;
      if (if_got) if_pend = 0;
      if (d_got)  d_pend  = 0;
      if (rel) begin
         rst_n   = 1'b1;
         free_at = cyc;
      end
      if (st && !d_pend) begin
         d_pend = 1; d_we_v = 1'b1; d_a = 32'h40; d_wd = 32'hDEADBEEF;
      end
      if (!if_pend && $urandom_range(0, 99) < p_if) begin
         if_pend = 1;
         if_a    = $urandom & 32'h0000_00FC;
      end
      if (!d_pend && $urandom_range(0, 99) < p_d) begin
         d_pend = 1;
         d_we_v = 1'($urandom_range(0, 1));
         d_a    = $urandom & 32'h0000_00FC;
         d_wd   = $urandom;
      end
      drive();
      if (pulse) begin
         #1 rst_n = 1'b0;
         #1 chk_all_zero("async_rst");
         sb_q.delete();
         starve  = 0;
         free_at = cyc;
         rst_n   = 1'b1;
      end
      @(negedge clk);
      idle = (cyc >= free_at);
      e_f  = 0;
      e_d  = 0;
      if (idle && (if_pend || d_pend)) begin
         if (if_pend && (!d_pend || starve == SLIM)) e_f = 1;
         else e_d = 1;
      end
      chk("if_gnt", bus.if_gnt, e_f);
      chk("d_gnt", bus.d_gnt, e_d);
      chk("mem_en", bus.mem_en, e_f | e_d);
      if (e_f) begin
         chk("fetch_mem_addr", bus.mem_addr, if_a);
         chk("fetch_mem_we", bus.mem_we, 0);
         rd = mem_rd(if_a);
         sb_q.push_back('{is_d: 1'b0, data: rd, due: cyc + LAT});
         bus.mem_rdata = rd;
         starve  = 0;
         free_at = cyc + LAT + 1;
      end else if (e_d) begin
         chk("data_mem_addr", bus.mem_addr, d_a);
         chk("data_mem_we", bus.mem_we, d_we_v);
         if (d_we_v) begin
            chk("store_mem_wdata", bus.mem_wdata, d_wd);
            sb_q.push_back('{is_d: 1'b1, data: '0, due: cyc + LAT});
            mem[d_a]      = d_wd;
            bus.mem_rdata = $urandom;
         end else begin
            rd = mem_rd(d_a);
            sb_q.push_back('{is_d: 1'b1, data: rd, due: cyc + LAT});
            bus.mem_rdata = rd;
         end
         if (if_pend && starve < SLIM) starve++;
         free_at = cyc + LAT + 1;
      end else if (idle) begin
         chk("idle_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      end
      if_got = bus.if_gnt;
      d_got  = bus.d_gnt;
   endtask

   // Response monitor: every rvalid must match the oldest outstanding access.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.if_rvalid || bus.d_rvalid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
         end else begin
            e = sb_q.pop_front();
            chk("rvalid_port", {bus.if_rvalid, bus.d_rvalid}, e.is_d ? 2'b01 : 2'b10);
            chk("rvalid_cycle", cyc, e.due);
            chk("if_rdata", bus.if_rdata, e.is_d ? '0 : e.data);
            chk("d_rdata", bus.d_rdata, e.is_d ? e.data : '0);
         end
      end else begin
         chk("rdata_quiet_zero", {bus.if_rdata, bus.d_rdata}, 0);
         if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk("missing_rvalid", {bus.if_rvalid, bus.d_rvalid}, e.is_d ? 2'b01 : 2'b10);
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      if_pend = 1; if_a = 32'h100;
      d_pend  = 0; d_we_v = 1'b0; d_a = '0; d_wd = '0;
      if_got  = 0; d_got = 0;
      drive();
      bus.mem_rdata = '0;
      #3 chk_all_zero("reset_state");
      @(negedge clk);
      chk_all_zero("reset_held");

      step(100, 0, 1, 0, 0);                  // release: fetch 0x100 granted at once
      repeat (5) step(100, 0, 0, 0, 0);       // back-to-back fetches
      repeat (4) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);                    // store 0xDEADBEEF to 0x40
      repeat (4) step(0, 0, 0, 0, 0);
      repeat (40) step(100, 100, 0, 0, 0);    // both ports saturated: starvation rotation
      repeat (4) step(0, 0, 0, 0, 0);
      step(100, 0, 0, 0, 0);                  // fetch grant
      step(100, 0, 0, 1, 0);                  // reset pulse in its first BUSY cycle
      repeat (6) step(100, 0, 0, 0, 0);
      repeat (400) step(50, 40, 0, 0, 0);     // random mix
      repeat (8) step(0, 0, 0, 0, 0);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from memory issue to read data valid; legal range 1..15.
REQ-004 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch-blocking data grants before fetch is forced; legal range 1..15.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port if_req  in  1  instruction-fetch request.
REQ-008 SHALL have port if_addr  in  ADDR_WIDTH  fetch address.
REQ-009 SHALL have port if_gnt  out  1  fetch request accepted this cycle.
REQ-010 SHALL have port if_rvalid  out  1  fetch data valid pulse.
REQ-011 SHALL have port if_rdata  out  DATA_WIDTH  fetch data.
REQ-012 SHALL have port d_req  in  1  load/store request.
REQ-013 SHALL have port d_we  in  1  1 = store, 0 = load.
REQ-014 SHALL have port d_addr  in  ADDR_WIDTH  data address.
REQ-015 SHALL have port d_wdata  in  DATA_WIDTH  store data.
REQ-016 SHALL have port d_gnt  out  1  data request accepted this cycle.
REQ-017 SHALL have port d_rvalid  out  1  load data valid / store complete pulse.
REQ-018 SHALL have port d_rdata  out  DATA_WIDTH  load data.
REQ-019 SHALL have ports mem_en, mem_we  out  1  single-port memory issue strobe and write enable.
REQ-020 SHALL have ports mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH.

Function
REQ-021 SHALL implement FSM states IDLE and BUSY, plus a latency counter and a starvation counter, both 4 bits.
REQ-022 In IDLE with any req high, SHALL assert exactly one gnt combinationally, assert mem_en, drive mem_addr/mem_we/mem_wdata from the winner (mem_we = d_we for data, 0 for fetch), record the owner, and move to BUSY with counter = 1.
REQ-023 In IDLE with no req, SHALL stay in IDLE with gnt, mem_en, mem_we low and mem_addr/mem_wdata = 0.
REQ-024 Priority SHALL be data over fetch, unless the starvation counter equals STARVE_LIMIT; then fetch wins.
REQ-025 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each data grant while if_req is high; it SHALL clear on each fetch grant; otherwise it SHALL hold.
REQ-026 In BUSY, no gnt and no mem_en SHALL be asserted; the counter SHALL increment each cycle.
REQ-027 In the BUSY cycle where counter == MEM_LATENCY, the owner's rvalid SHALL pulse for one cycle with rdata = mem_rdata; the FSM SHALL then return to IDLE.
REQ-028 The next grant SHALL occur no earlier than the cycle after rvalid, so each access occupies MEM_LATENCY+1 cycles.
REQ-029 Stores SHALL also produce a d_rvalid pulse, with d_rdata = 0.
REQ-030 Outside its rvalid pulse, each rdata SHALL be 0; the non-owner's rvalid SHALL never assert.
REQ-031 Requesters hold req/addr/wdata stable until gnt; a req dropped before gnt SHALL be ignored, with no state change.

Reset
REQ-032 rst_n low SHALL immediately, without waiting for clk, force IDLE, clear both counters and owner, and drive every output to 0.
REQ-033 Reset during BUSY SHALL drop the in-flight response: no rvalid SHALL follow after rst_n rises.
REQ-034 The first grant after reset SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-035 Single fetch, MEM_LATENCY=2: if_req, if_addr=0x100 at cycle 0 -> if_gnt=1 and mem_en=1, mem_addr=0x100 in cycle 0; if_rvalid=1 and if_rdata=mem_rdata in cycle 2; IDLE in cycle 3.
REQ-036 Simultaneous if_req and d_req (load 0x200), counter 0 -> d_gnt first; if_gnt in cycle 3.
REQ-037 Starvation, STARVE_LIMIT=4: if_req and d_req held continuously -> 4 data grants, then 1 fetch grant, repeating; counter returns to 0 after the fetch grant.
REQ-038 Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF in the grant cycle; d_rvalid=1 with d_rdata=0 in cycle MEM_LATENCY.
REQ-039 rst_n pulsed low in cycle 1 of a fetch -> all outputs 0 asynchronously; no if_rvalid afterwards; a new if_req is granted on the first edge after release.
REQ-040 MEM_LATENCY=1 back-to-back fetches -> a grant every 2 cycles, and rvalid in the cycle after each grant.
